// File: rtl/nmr_nosig_delay_timer_if.sv
// Control/status bundle between the parameter registers, the pulse sequencer,
// and the no-signal dead-time / acquisition-gate timer.
interface nmr_nosig_delay_timer_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] delay_nosig;
    logic [WIDTH-1:0] acq_len;
    logic             start;
    logic             abort;
    logic             clr_overrun;
    logic             busy;
    logic             acq_en;
    logic             done;
    logic             overrun;

    modport master (
        output delay_nosig, acq_len, start, abort, clr_overrun,
        input  busy, acq_en, done, overrun
    );

    modport slave (
        input  delay_nosig, acq_len, start, abort, clr_overrun,
        output busy, acq_en, done, overrun
    );
endinterface

// File: rtl/nmr_nosig_delay_timer.sv
// After each RF pulse-end strobe, waits the programmed ring-down dead time and
// then opens the ADC acquisition gate for a programmed number of cycles.
module nmr_nosig_delay_timer #(
    parameter int WIDTH     = 32,
    parameter int MIN_DELAY = 1
) (
    input  logic                          clk,
    input  logic                          reset_n,
    nmr_nosig_delay_timer_if.slave        bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DELAY = 2'd1,
        ST_ACQ   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0] MIN_D = WIDTH'(MIN_DELAY);
    localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);
    localparam logic [WIDTH-1:0] ZERO  = WIDTH'(0);

    state_t           state_r;
    state_t           state_s;
    logic [WIDTH-1:0] cnt_r;
    logic [WIDTH-1:0] cnt_s;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] a_s;
    logic [WIDTH-1:0] d_clamp_s;
    logic             accept_s;
    logic             ovr_set_s;
    logic             overrun_s;
    logic             busy_r;
    logic             acq_en_r;
    logic             done_r;
    logic             overrun_r;

    // Next-state, counter and overrun logic; DONE accepts a start just like IDLE.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        a_s       = a_r;
        d_clamp_s = (bus.delay_nosig < MIN_D) ? MIN_D : bus.delay_nosig;
        accept_s  = bus.start && !bus.abort &&
                    ((state_r == ST_IDLE) || (state_r == ST_DONE));
        ovr_set_s = bus.start && !bus.abort &&
                    ((state_r == ST_DELAY) || (state_r == ST_ACQ));

        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (accept_s) begin
                    state_s = ST_DELAY;
                    a_s     = bus.acq_len;
                    cnt_s   = d_clamp_s - ONE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_DELAY: begin
                if (bus.abort) begin
                    state_s = ST_IDLE;
                    cnt_s   = ZERO;
                end else if (cnt_r == ZERO) begin
                    if (a_r != ZERO) begin
                        state_s = ST_ACQ;
                        cnt_s   = a_r - ONE;
                    end else begin
                        state_s = ST_DONE;
                    end
                end else begin
                    cnt_s = cnt_r - ONE;
                end
            end
            ST_ACQ: begin
                if (bus.abort) begin
                    state_s = ST_IDLE;
                    cnt_s   = ZERO;
                end else if (cnt_r == ZERO) begin
                    state_s = ST_DONE;
                end else begin
                    cnt_s = cnt_r - ONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = ZERO;
            end
        endcase

        // A set in the same cycle as a clear must win so no overrun is lost.
        if (ovr_set_s) begin
            overrun_s = 1'b1;
        end else if (bus.clr_overrun) begin
            overrun_s = 1'b0;
        end else begin
            overrun_s = overrun_r;
        end
    end

    // State, counters and registered outputs decoded from the next state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= ST_IDLE;
            cnt_r     <= ZERO;
            a_r       <= ZERO;
            busy_r    <= 1'b0;
            acq_en_r  <= 1'b0;
            done_r    <= 1'b0;
            overrun_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            a_r       <= a_s;
            busy_r    <= (state_s == ST_DELAY) || (state_s == ST_ACQ);
            acq_en_r  <= (state_s == ST_ACQ);
            done_r    <= (state_s == ST_DONE);
            overrun_r <= overrun_s;
        end
    end

    assign bus.busy    = busy_r;
    assign bus.acq_en  = acq_en_r;
    assign bus.done    = done_r;
    assign bus.overrun = overrun_r;

endmodule

// File: tb/tb_nmr_nosig_delay_timer.sv
// Directed, table-driven bench for nmr_nosig_delay_timer; cycle 0 is the cycle
// in which start is high, outputs are sampled 1 time unit after each rising edge.
module tb_nmr_nosig_delay_timer;

    logic clk = 1'b0;
    logic reset_n;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    nmr_nosig_delay_timer_if #(.WIDTH(32)) bus ();

    nmr_nosig_delay_timer #(.WIDTH(32), .MIN_DELAY(1)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // ev_kind: 0 none, 1 delay_nosig->100 at ev_cyc, 2 extra start at ev_cyc,
    // 3 extra start at ev_cyc and start+clr_overrun at ev_cyc+2
    typedef struct {
        logic [31:0] d;
        logic [31:0] a;
        int          ev_cyc;
        int          ev_kind;
        int          blo, bhi, alo, ahi, dcyc, ovfrom;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string nm, input int cyc, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%b want=%b", nm, cyc, act, exp);
        end
    endtask

    function automatic logic inw(input int c, input int lo, input int hi);
        return (c >= lo) && (c <= hi);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ovr();
        bus.clr_overrun = 1'b1;
        step();
        bus.clr_overrun = 1'b0;
        chk("overrun_clear", 0, bus.overrun, 1'b0);
    endtask

    initial begin
        vecs[0] = '{32'd16, 32'd4, 0, 0, 1, 20, 17, 20, 21, 0};
        vecs[1] = '{32'd0,  32'd0, 0, 0, 1, 1,  1,  0,  2,  0};
        vecs[2] = '{32'd10, 32'd3, 5, 1, 1, 13, 11, 13, 14, 0};
        vecs[3] = '{32'd20, 32'd2, 5, 2, 1, 22, 21, 22, 23, 6};
        vecs[4] = '{32'd20, 32'd2, 3, 3, 1, 22, 21, 22, 23, 4};
        vecs[5] = '{32'd1,  32'd1, 0, 0, 1, 2,  2,  2,  3,  0};

        reset_n         = 1'b0;
        bus.delay_nosig = 32'd16;
        bus.acq_len     = 32'd4;
        bus.start       = 1'b0;
        bus.abort       = 1'b0;
        bus.clr_overrun = 1'b0;
        #12;
        chk("rst_busy",    0, bus.busy,    1'b0);
        chk("rst_acq_en",  0, bus.acq_en,  1'b0);
        chk("rst_done",    0, bus.done,    1'b0);
        chk("rst_overrun", 0, bus.overrun, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        step();

        for (int i = 0; i < 6; i++) begin
            clear_ovr();
            bus.delay_nosig = vecs[i].d;
            bus.acq_len     = vecs[i].a;
            bus.start       = 1'b1;
            step();
            bus.start = 1'b0;
            for (int c = 1; c <= vecs[i].dcyc + 1; c++) begin
                chk($sformatf("v%0d_busy", i),    c, bus.busy,    inw(c, vecs[i].blo, vecs[i].bhi));
                chk($sformatf("v%0d_acq_en", i),  c, bus.acq_en,  inw(c, vecs[i].alo, vecs[i].ahi));
                chk($sformatf("v%0d_done", i),    c, bus.done,    logic'(c == vecs[i].dcyc));
                chk($sformatf("v%0d_overrun", i), c, bus.overrun,
                    logic'((vecs[i].ovfrom != 0) && (c >= vecs[i].ovfrom)));
                bus.start       = (vecs[i].ev_kind >= 2) && (c == vecs[i].ev_cyc) ||
                                  (vecs[i].ev_kind == 3) && (c == vecs[i].ev_cyc + 2);
                bus.clr_overrun = (vecs[i].ev_kind == 3) && (c == vecs[i].ev_cyc + 2);
                if ((vecs[i].ev_kind == 1) && (c == vecs[i].ev_cyc)) begin
                    bus.delay_nosig = 32'd100;
                end
                step();
            end
            bus.start       = 1'b0;
            bus.clr_overrun = 1'b0;
        end

        // Back-to-back: second start lands in the done cycle of the first.
        clear_ovr();
        bus.delay_nosig = 32'd5;
        bus.acq_len     = 32'd2;
        bus.start       = 1'b1;
        step();
        bus.start = 1'b0;
        for (int c = 1; c <= 17; c++) begin
            chk("b2b_busy",    c, bus.busy,    inw(c, 1, 7) || inw(c, 9, 15));
            chk("b2b_acq_en",  c, bus.acq_en,  inw(c, 6, 7) || inw(c, 14, 15));
            chk("b2b_done",    c, bus.done,    logic'((c == 8) || (c == 16)));
            chk("b2b_overrun", c, bus.overrun, 1'b0);
            bus.start = (c == 8);
            step();
        end
        bus.start = 1'b0;

        // Abort in cycle 12 (ACQ) of a delay 8 / acq 8 sequence.
        bus.delay_nosig = 32'd8;
        bus.acq_len     = 32'd8;
        bus.start       = 1'b1;
        step();
        bus.start = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            chk("abort_busy",   c, bus.busy,   inw(c, 1, 12));
            chk("abort_acq_en", c, bus.acq_en, inw(c, 9, 12));
            chk("abort_done",   c, bus.done,   1'b0);
            bus.abort = (c == 12);
            step();
        end

        // Abort and start together in IDLE: start dropped, no overrun.
        bus.abort = 1'b1;
        bus.start = 1'b1;
        step();
        bus.abort = 1'b0;
        bus.start = 1'b0;
        chk("abort_start_busy",    1, bus.busy,    1'b0);
        chk("abort_start_overrun", 1, bus.overrun, 1'b0);
        step();
        chk("abort_start_busy2",   2, bus.busy,    1'b0);

        // Reset pulled low mid-ACQ with overrun already set.
        bus.delay_nosig = 32'd3;
        bus.acq_len     = 32'd5;
        bus.start       = 1'b1;
        step();
        bus.start = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            chk("rstseq_acq_en", c, bus.acq_en, inw(c, 4, 8));
            bus.start = (c == 2);
            if (c < 5) begin
                step();
            end else begin
                chk("rstseq_overrun", c, bus.overrun, 1'b1);
            end
        end
        bus.start = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst_busy",    5, bus.busy,    1'b0);
        chk("async_rst_acq_en",  5, bus.acq_en,  1'b0);
        chk("async_rst_done",    5, bus.done,    1'b0);
        chk("async_rst_overrun", 5, bus.overrun, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            step();
            chk("post_rst_busy", c, bus.busy, 1'b0);
            chk("post_rst_done", c, bus.done, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
